// File: rtl/mem2axi_pkg.sv
// rtl/mem2axi_pkg.sv - shared FSM state type and AXI field constants for mem2axi_master
package mem2axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_8B     = 3'b011;

endpackage

// File: rtl/mem2axi_master.sv
// rtl/mem2axi_master.sv - single-outstanding memory request to AXI4 single-beat initiator
module mem2axi_master
    import mem2axi_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 0,
    parameter int FIXED_ID       = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]                be_i,
    input  logic [63:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [63:0]               rdata_o,
    output logic                      err_o,

    output logic [AXI_ID_WIDTH-1:0]   aw_id_o,
    output logic [AXI_ADDR_WIDTH-1:0] aw_addr_o,
    output logic [7:0]                aw_len_o,
    output logic [2:0]                aw_size_o,
    output logic [1:0]                aw_burst_o,
    output logic                      aw_lock_o,
    output logic [3:0]                aw_cache_o,
    output logic [2:0]                aw_prot_o,
    output logic [3:0]                aw_qos_o,
    output logic [3:0]                aw_region_o,
    output logic [((AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1)-1:0] aw_user_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,

    output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
    output logic                        w_last_o,
    output logic [((AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1)-1:0] w_user_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,

    input  logic [AXI_ID_WIDTH-1:0]   b_id_i,
    input  logic [1:0]                b_resp_i,
    input  logic [((AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1)-1:0] b_user_i,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,

    output logic [AXI_ID_WIDTH-1:0]   ar_id_o,
    output logic [AXI_ADDR_WIDTH-1:0] ar_addr_o,
    output logic [7:0]                ar_len_o,
    output logic [2:0]                ar_size_o,
    output logic [1:0]                ar_burst_o,
    output logic                      ar_lock_o,
    output logic [3:0]                ar_cache_o,
    output logic [2:0]                ar_prot_o,
    output logic [3:0]                ar_qos_o,
    output logic [3:0]                ar_region_o,
    output logic [((AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1)-1:0] ar_user_o,
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,

    input  logic [AXI_ID_WIDTH-1:0]   r_id_i,
    input  logic [AXI_DATA_WIDTH-1:0] r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i,
    input  logic [((AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1)-1:0] r_user_i,
    input  logic                      r_valid_i,
    output logic                      r_ready_o
);

    state_e                    state_q, state_d;
    logic                      we_q, we_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                be_q, be_d;
    logic [63:0]               wdata_q, wdata_d;
    logic                      aw_valid_q, aw_valid_d;
    logic                      w_valid_q, w_valid_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      b_ready_q, b_ready_d;
    logic                      ar_valid_q, ar_valid_d;
    logic                      r_ready_q, r_ready_d;
    logic                      rvalid_q, rvalid_d;
    logic                      err_q, err_d;
    logic [63:0]               rdata_q, rdata_d;
    logic                      rsp_hs;

    // Response IDs and user bits carry nothing for a single-outstanding initiator.
    logic unused_ok;
    assign unused_ok = ^{b_id_i, b_user_i, r_id_i, r_user_i};

    // The completion cycle already sits in IDLE, so it is masked to keep one idle gap.
    assign gnt_o = req_i && (state_q == ST_IDLE) && !rvalid_q && !rst_i;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_o) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    be_d    = be_i;
                    wdata_d = wdata_i;
                    if (we_i) begin
                        state_d    = ST_WRITE;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                    end else begin
                        state_d    = ST_RADDR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (aw_valid_q && aw_ready_i) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_valid_q && w_ready_i) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_WRESP;
                    b_ready_d = 1'b1;
                end
            end
            ST_WRESP: begin
                if (b_valid_i) begin
                    b_ready_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (r_valid_i) begin
                    r_ready_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rsp_hs = (b_ready_q && b_valid_i) || (r_ready_q && r_valid_i);
        if (rsp_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = we_q ? 64'd0 : r_data_i;
            err_d    = we_q ? (b_resp_i != RESP_OKAY)
                            : ((r_resp_i != RESP_OKAY) || !r_last_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;

    assign aw_id_o     = AXI_ID_WIDTH'(FIXED_ID);
    assign aw_addr_o   = addr_q;
    assign aw_len_o    = 8'd0;
    assign aw_size_o   = SIZE_8B;
    assign aw_burst_o  = BURST_INCR;
    assign aw_lock_o   = 1'b0;
    assign aw_cache_o  = 4'd0;
    assign aw_prot_o   = 3'd0;
    assign aw_qos_o    = 4'd0;
    assign aw_region_o = 4'd0;
    assign aw_user_o   = '0;
    assign aw_valid_o  = aw_valid_q;

    assign w_data_o  = wdata_q;
    assign w_strb_o  = be_q;
    assign w_last_o  = 1'b1;
    assign w_user_o  = '0;
    assign w_valid_o = w_valid_q;

    assign b_ready_o = b_ready_q;

    assign ar_id_o     = AXI_ID_WIDTH'(FIXED_ID);
    assign ar_addr_o   = addr_q;
    assign ar_len_o    = 8'd0;
    assign ar_size_o   = SIZE_8B;
    assign ar_burst_o  = BURST_INCR;
    assign ar_lock_o   = 1'b0;
    assign ar_cache_o  = 4'd0;
    assign ar_prot_o   = 3'd0;
    assign ar_qos_o    = 4'd0;
    assign ar_region_o = 4'd0;
    assign ar_user_o   = '0;
    assign ar_valid_o  = ar_valid_q;

    assign r_ready_o = r_ready_q;

endmodule

// File: tb/tb_mem2axi_master.sv
// tb/tb_mem2axi_master.sv - scoreboard bench for mem2axi_master with a scripted AXI responder
module tb_mem2axi_master;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        gnt, rvalid, err;
    logic [63:0] rdata;

    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic        aw_lock, ar_lock;
    logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
    logic [0:0]  aw_user, w_user, ar_user, b_user, r_user;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic        b_valid, b_ready, ar_valid, ar_ready;
    logic        r_valid, r_ready, r_last;
    logic [63:0] w_data, r_data;
    logic [7:0]  w_strb;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rvalid = 0;
    int   n_aw = 0;
    int   n_w = 0;
    int   n_ar = 0;

    always #5 clk = ~clk;

    mem2axi_master dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .aw_id_o(aw_id), .aw_addr_o(aw_addr), .aw_len_o(aw_len), .aw_size_o(aw_size),
        .aw_burst_o(aw_burst), .aw_lock_o(aw_lock), .aw_cache_o(aw_cache), .aw_prot_o(aw_prot),
        .aw_qos_o(aw_qos), .aw_region_o(aw_region), .aw_user_o(aw_user),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
        .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last), .w_user_o(w_user),
        .w_valid_o(w_valid), .w_ready_i(w_ready),
        .b_id_i(b_id), .b_resp_i(b_resp), .b_user_i(b_user), .b_valid_i(b_valid), .b_ready_o(b_ready),
        .ar_id_o(ar_id), .ar_addr_o(ar_addr), .ar_len_o(ar_len), .ar_size_o(ar_size),
        .ar_burst_o(ar_burst), .ar_lock_o(ar_lock), .ar_cache_o(ar_cache), .ar_prot_o(ar_prot),
        .ar_qos_o(ar_qos), .ar_region_o(ar_region), .ar_user_o(ar_user),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
        .r_id_i(r_id), .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last), .r_user_i(r_user),
        .r_valid_i(r_valid), .r_ready_o(r_ready)
    );

    // Inputs are final when tick is entered, so handshakes counted here are the ones the next edge sees.
    task automatic tick();
        exp_t e;
        if (aw_valid && aw_ready) n_aw++;
        if (w_valid && w_ready) n_w++;
        if (ar_valid && ar_ready) n_ar++;
        @(negedge clk);
        #1;
        if (rvalid) begin
            n_rvalid++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rvalid: rdata_o=%h err_o=%b with empty scoreboard", rdata, err);
            end else begin
                e = exp_q.pop_front();
                if (rdata !== e.data || err !== e.err) begin
                    n_bad++;
                    $display("FAIL completion: rdata_o=%h err_o=%b required rdata=%h err=%b",
                             rdata, err, e.data, e.err);
                end
            end
        end
    endtask

    task automatic wait_grant(input string nm);
        int c;
        c = 0;
        #1;
        while (!gnt && c < 20) begin
            tick();
            c++;
        end
        n_cmp++;
        if (!gnt) begin
            n_bad++;
            $display("FAIL %s_grant: gnt_o=%b required 1 within 20 cycles", nm, gnt);
        end
        tick();
        req = 1'b0;
    endtask

    task automatic do_write(input string nm, input logic [31:0] a, input logic [7:0] b,
                            input logic [63:0] d, input int aw_dly, input int w_dly,
                            input int b_dly, input logic [1:0] resp);
        int  c;
        int  rv0;
        bit  awd, wd;
        exp_q.push_back('{data: 64'd0, err: (resp != 2'b00)});
        rv0 = n_rvalid;
        req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
        wait_grant(nm);
        awd = 0; wd = 0; c = 0;
        while (!(awd && wd) && c < 40) begin
            n_cmp++;
            if (aw_valid !== !awd || w_valid !== !wd) begin
                n_bad++;
                $display("FAIL %s_valids c=%0d: aw_valid=%b w_valid=%b required %b %b",
                         nm, c, aw_valid, w_valid, !awd, !wd);
            end
            if (!awd) begin
                n_cmp++;
                if ({aw_addr, aw_len, aw_size, aw_burst, aw_id} !== {a, 8'd0, 3'd3, 2'b01, 4'd0} ||
                    {aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_user} !== 16'd0) begin
                    n_bad++;
                    $display("FAIL %s_aw_payload: addr=%h len=%h size=%h burst=%h id=%h required addr=%h len=0 size=3 burst=1 id=0",
                             nm, aw_addr, aw_len, aw_size, aw_burst, aw_id, a);
                end
            end
            if (!wd) begin
                n_cmp++;
                if ({w_data, w_strb, w_last, w_user} !== {d, b, 1'b1, 1'b0}) begin
                    n_bad++;
                    $display("FAIL %s_w_payload: data=%h strb=%h last=%b required data=%h strb=%h last=1",
                             nm, w_data, w_strb, w_last, d, b);
                end
            end
            aw_ready = !awd && (c >= aw_dly);
            w_ready  = !wd && (c >= w_dly);
            if (aw_ready) awd = 1;
            if (w_ready) wd = 1;
            tick();
            c++;
        end
        aw_ready = 1'b0; w_ready = 1'b0;
        n_cmp++;
        if (aw_valid !== 1'b0 || w_valid !== 1'b0 || b_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_wresp_entry: aw_valid=%b w_valid=%b b_ready=%b required 0 0 1",
                     nm, aw_valid, w_valid, b_ready);
        end
        for (int i = 0; i < b_dly; i++) tick();
        b_valid = 1'b1; b_resp = resp; b_id = 4'hF;
        tick();
        b_valid = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b1 || gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_b_latency: rvalid_o=%b gnt_o=%b required 1 0", nm, rvalid, gnt);
        end
        tick();
        n_cmp++;
        if (rvalid !== 1'b0 || n_rvalid - rv0 != 1) begin
            n_bad++;
            $display("FAIL %s_pulse: rvalid_o=%b pulses=%0d required 0 and 1 pulse",
                     nm, rvalid, n_rvalid - rv0);
        end
    endtask

    task automatic do_read(input string nm, input logic [31:0] a, input int ar_dly,
                           input int r_dly, input logic [63:0] d, input logic [1:0] resp,
                           input logic last);
        int c;
        int rv0;
        exp_q.push_back('{data: d, err: (resp != 2'b00) || !last});
        rv0 = n_rvalid;
        req = 1'b1; we = 1'b0; addr = a;
        wait_grant(nm);
        for (c = 0; c <= ar_dly; c++) begin
            n_cmp++;
            if (ar_valid !== 1'b1 ||
                {ar_addr, ar_len, ar_size, ar_burst, ar_id} !== {a, 8'd0, 3'd3, 2'b01, 4'd0}) begin
                n_bad++;
                $display("FAIL %s_ar c=%0d: ar_valid=%b addr=%h len=%h size=%h burst=%h required 1 %h 0 3 1",
                         nm, c, ar_valid, ar_addr, ar_len, ar_size, ar_burst, a);
            end
            ar_ready = (c == ar_dly);
            tick();
        end
        ar_ready = 1'b0;
        n_cmp++;
        if (ar_valid !== 1'b0 || r_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_rdata_entry: ar_valid=%b r_ready=%b required 0 1", nm, ar_valid, r_ready);
        end
        for (int i = 0; i < r_dly; i++) tick();
        r_valid = 1'b1; r_data = d; r_resp = resp; r_last = last; r_id = 4'hA;
        tick();
        r_valid = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b1 || gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_r_latency: rvalid_o=%b gnt_o=%b required 1 0", nm, rvalid, gnt);
        end
        tick();
        n_cmp++;
        if (rvalid !== 1'b0 || n_rvalid - rv0 != 1) begin
            n_bad++;
            $display("FAIL %s_pulse: rvalid_o=%b pulses=%0d required 0 and 1 pulse",
                     nm, rvalid, n_rvalid - rv0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h1234_5678; be = 8'hFF; wdata = '1;
        tick();
        tick();
        n_cmp++;
        if ({gnt, aw_valid, w_valid, ar_valid, b_ready, r_ready, rvalid, err} !== 8'd0 ||
            rdata !== 64'd0 || aw_addr !== 32'd0 || w_data !== 64'd0 || w_strb !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_state: gnt=%b aw=%b w=%b ar=%b b=%b r=%b rv=%b err=%b rdata=%h addr=%h required all 0",
                     gnt, aw_valid, w_valid, ar_valid, b_ready, r_ready, rvalid, err, rdata, aw_addr);
        end
        req = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_basic();
        do_write("wr_basic", 32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 0, 2'b00);
        do_write("wr_be0", 32'h8000_0018, 8'h00, 64'hAAAA_5555_0F0F_F0F0, 0, 0, 2, 2'b10);
    endtask

    task automatic test_read();
        do_read("rd_basic", 32'h8000_0008, 2, 1, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (rdata !== 64'hDEAD_BEEF_CAFE_F00D) begin
            n_bad++;
            $display("FAIL rdata_hold: rdata_o=%h required DEADBEEFCAFEF00D", rdata);
        end
    endtask

    task automatic test_write_order();
        do_write("wr_w_first", 32'h0000_0100, 8'h0F, 64'h0102_0304_0506_0708, 3, 0, 1, 2'b00);
        do_write("wr_aw_first", 32'h0000_0200, 8'hF0, 64'h8070_6050_4030_2010, 0, 3, 0, 2'b00);
    endtask

    task automatic test_read_errors();
        do_read("rd_slverr", 32'h0000_0040, 0, 0, 64'h0BAD_0BAD_0BAD_0BAD, 2'b10, 1'b1);
        do_read("rd_nolast", 32'h0000_0048, 1, 2, 64'h1357_9BDF_2468_ACE0, 2'b00, 1'b0);
    endtask

    task automatic test_back_to_back();
        int grants, c, ar0, rv0;
        grants = 0; c = 0; ar0 = n_ar; rv0 = n_rvalid;
        req = 1'b1; we = 1'b0; addr = 32'h4000_0000;
        ar_ready = 1'b1; r_valid = 1'b1; r_data = 64'h0123_4567_89AB_CDEF; r_resp = 2'b00; r_last = 1'b1;
        #1;
        while (c < 60 && (grants < 4 || n_rvalid - rv0 < 4)) begin
            if (gnt) begin
                n_cmp++;
                if (ar_valid || r_ready || rvalid) begin
                    n_bad++;
                    $display("FAIL b2b_busy_grant: gnt_o=1 with ar_valid=%b r_ready=%b rvalid_o=%b required idle",
                             ar_valid, r_ready, rvalid);
                end
                grants++;
                exp_q.push_back('{data: 64'h0123_4567_89AB_CDEF, err: 1'b0});
            end
            tick();
            c++;
            if (grants == 4) req = 1'b0;
        end
        ar_ready = 1'b0; r_valid = 1'b0;
        n_cmp++;
        if (grants != 4 || n_ar - ar0 != 4 || n_rvalid - rv0 != 4) begin
            n_bad++;
            $display("FAIL b2b_counts: grants=%0d ar=%0d rvalid=%0d required 4 4 4",
                     grants, n_ar - ar0, n_rvalid - rv0);
        end
    endtask

    task automatic test_reset_in_wresp();
        int rv0;
        rv0 = n_rvalid;
        req = 1'b1; we = 1'b1; addr = 32'h0000_0300; be = 8'h3C; wdata = 64'hFACE_FACE_FACE_FACE;
        wait_grant("rst_wresp");
        aw_ready = 1'b1; w_ready = 1'b1;
        tick();
        aw_ready = 1'b0; w_ready = 1'b0;
        n_cmp++;
        if (b_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_wresp_entry: b_ready=%b required 1", b_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, rvalid, err} !== 7'd0) begin
            n_bad++;
            $display("FAIL rst_wresp_clear: aw=%b w=%b ar=%b b=%b r=%b rv=%b err=%b required all 0",
                     aw_valid, w_valid, ar_valid, b_ready, r_ready, rvalid, err);
        end
        req = 1'b1; we = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_wresp_idle: gnt_o=%b required 1 (IDLE after reset)", gnt);
        end
        req = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (n_rvalid != rv0) begin
            n_bad++;
            $display("FAIL rst_wresp_no_pulse: pulses=%0d required 0", n_rvalid - rv0);
        end
        do_write("after_rst", 32'h0000_0308, 8'hC3, 64'h5A5A_A5A5_5A5A_A5A5, 1, 2, 1, 2'b00);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
        b_valid = 1'b0; b_resp = 2'b00; b_id = '0; b_user = '0;
        r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0; r_id = '0; r_user = '0;
        test_reset();
        test_write_basic();
        test_read();
        test_write_order();
        test_read_errors();
        test_back_to_back();
        test_reset_in_wresp();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d completions outstanding required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem2axi_master.md
MEM2AXI_MASTER -- requirements
Module: mem2axi_master

Interface
REQ-001 Parameter AXI_ID_WIDTH, default 4, sets the AXI ID width.
REQ-002 Parameter AXI_ADDR_WIDTH, default 32, sets the AXI address width.
REQ-003 Parameter AXI_DATA_WIDTH, default 64, sets the data width; only 64 is supported.
REQ-004 Parameter AXI_USER_WIDTH, default 0, sets the user width; all user outputs SHALL be driven to 0.
REQ-005 Parameter FIXED_ID, default 0, is the ID on every AW and AR.
REQ-006 clk_i  input  1  single clock; all logic on its rising edge.
REQ-007 rst_i  input  1  reset, synchronous and active-high.
REQ-008 req_i  input  1  memory-side request valid.
REQ-009 we_i  input  1  1 = write, 0 = read.
REQ-010 addr_i  input  AXI_ADDR_WIDTH  byte address.
REQ-011 be_i  input  8  write byte enables.
REQ-012 wdata_i  input  64  write data.
REQ-013 gnt_o  output  1  request accepted this cycle.
REQ-014 rvalid_o  output  1  one-cycle completion pulse for read or write.
REQ-015 rdata_o  output  64  read data, valid with rvalid_o.
REQ-016 err_o  output  1  completion error, valid with rvalid_o.
REQ-017 master  AXI_BUS.Master  --  AXI4 initiator port.

Function
REQ-018 The block SHALL have one outstanding transaction at a time, with states IDLE, WRITE, WRESP, RADDR, RDATA.
REQ-019 gnt_o SHALL equal req_i AND (state==IDLE), combinationally.
REQ-020 On grant, the block SHALL register we_i, addr_i, be_i and wdata_i.
REQ-021 On grant, the next state SHALL be WRITE if we_i=1, else RADDR.
REQ-022 In WRITE, aw_valid and w_valid SHALL both be asserted from the cycle after grant.
REQ-023 In WRITE, each valid SHALL drop individually after its handshake; aw_done and w_done flags SHALL track completion.
REQ-024 WRITE SHALL go to WRESP when both handshakes are done; simultaneous and either-order handshakes are legal.
REQ-025 In WRESP, b_ready SHALL be 1; on a B handshake the block SHALL pulse rvalid_o with err_o = (b_resp != OKAY) and return to IDLE.
REQ-026 In RADDR, ar_valid SHALL be 1; on the AR handshake the state SHALL go to RDATA.
REQ-027 In RDATA, r_ready SHALL be 1; on an R handshake the block SHALL pulse rvalid_o with rdata_o = r_data, err_o = (r_resp != OKAY) OR NOT r_last, and return to IDLE.
REQ-028 Each valid SHALL stay asserted, with stable payload, until its handshake and SHALL never depend on the corresponding ready.
REQ-029 AW/AR fields: addr = captured address, unmodified; len=0; size=3; burst=INCR; lock, cache, prot, qos and region = 0; id = FIXED_ID.
REQ-030 W fields: data = captured wdata; strb = captured be; last=1.
REQ-031 be=0 on a write SHALL still issue the transaction, with strb=0.
REQ-032 The B and R ID fields SHALL be ignored.
REQ-033 rdata_o SHALL hold its last value between pulses and SHALL be 0 after write completions.
REQ-034 Minimum latency: grant at cycle 0, AW/W or AR valid at cycle 1, rvalid_o one cycle after the B/R handshake.
REQ-035 gnt_o SHALL be 0 outside IDLE, including the cycle of rvalid_o; the earliest next grant is the cycle after rvalid_o.

Reset
REQ-036 While rst_i=1 at a clock edge, state SHALL be IDLE and all AXI valids, b_ready, r_ready, rvalid_o and err_o SHALL be 0.
REQ-037 While rst_i=1 at a clock edge, rdata_o and the captured registers SHALL be 0.
REQ-038 Reset mid-transaction SHALL abort it with no rvalid_o pulse; the AXI responder is reset together with this block.
REQ-039 gnt_o SHALL be 0 while rst_i=1.

Structure
REQ-040 Package mem2axi_pkg SHALL hold the state enum and the constants BURST_INCR, RESP_OKAY, RESP_SLVERR and SIZE_8B.
REQ-041 No sub-module; a single FSM module, registered outputs apart from gnt_o.

Verification
REQ-042 Write 0x8000_0010, be=0xFF, data=0x1122334455667788, responder ready=1 -> one AW and one W (strb 0xFF, last 1), rvalid_o 1 pulse, err_o=0.
REQ-043 Read 0x8000_0008, responder returns 0xDEADBEEFCAFEF00D, OKAY, last=1 -> rdata_o=0xDEADBEEFCAFEF00D, err_o=0.
REQ-044 Write with w_ready 3 cycles before aw_ready, then the reverse order -> both complete, valids stable until handshake, exactly one rvalid_o each.
REQ-045 Read returning SLVERR, then a read with r_last=0 -> err_o=1 on both completions.
REQ-046 req_i held high for 4 back-to-back reads -> gnt_o never asserted while busy, 4 AR handshakes, 4 rvalid_o pulses.
REQ-047 rst_i asserted in WRESP -> next cycle all valids/readies 0, state IDLE, no rvalid_o; the following request completes normally.
